// File: rtl/fetch_buffer_if.sv
// Fetch-to-pre-decode bundle: the enqueue side from fetch, the release side to pre-decode,
// rename backpressure and the occupancy view. master = fetch/pre-decode side, slave = queue.
interface fetch_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]        in_inst_valid;
    logic [INST_W-1:0] in_inst_0,        in_inst_1;
    logic [ADDR_W-1:0] in_pc_0,          in_pc_1;
    logic              in_pred_taken_0,  in_pred_taken_1;
    logic [ADDR_W-1:0] in_pred_target_0, in_pred_target_1;
    logic [GHR_W-1:0]  in_pred_hist_0,   in_pred_hist_1;
    logic              in_ready;

    logic              stall;
    logic [1:0]        out_inst_valid;
    logic [INST_W-1:0] out_inst_0,        out_inst_1;
    logic [ADDR_W-1:0] out_pc_0,          out_pc_1;
    logic              out_pred_taken_0,  out_pred_taken_1;
    logic [ADDR_W-1:0] out_pred_target_0, out_pred_target_1;
    logic [GHR_W-1:0]  out_pred_hist_0,   out_pred_hist_1;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_inst_valid, in_inst_0, in_inst_1, in_pc_0, in_pc_1,
               in_pred_taken_0, in_pred_taken_1, in_pred_target_0, in_pred_target_1,
               in_pred_hist_0, in_pred_hist_1, stall,
        input  in_ready, out_inst_valid, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
               out_pred_taken_0, out_pred_taken_1, out_pred_target_0, out_pred_target_1,
               out_pred_hist_0, out_pred_hist_1, count
    );

    modport slave (
        input  in_inst_valid, in_inst_0, in_inst_1, in_pc_0, in_pc_1,
               in_pred_taken_0, in_pred_taken_1, in_pred_target_0, in_pred_target_1,
               in_pred_hist_0, in_pred_hist_1, stall,
        output in_ready, out_inst_valid, out_inst_0, out_inst_1, out_pc_0, out_pc_1,
               out_pred_taken_0, out_pred_taken_1, out_pred_target_0, out_pred_target_1,
               out_pred_hist_0, out_pred_hist_1, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Two-wide in-order instruction queue between fetch and pre-decode; releases a contiguous
// prefix of up to two entries per cycle and empties in one cycle on flush.
module fetch_buffer #(
    parameter int DEPTH  = 8,
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int GHR_W  = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    fetch_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              taken;
        logic [ADDR_W-1:0] target;
        logic [GHR_W-1:0]  hist;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              ready;
    logic [1:0]        wr_valid, avail, out_valid;
    logic [1:0]        enq_n, deq_n;
    logic [PTR_W-1:0]  head_p1, wr_idx1;
    entry_t            in_e0, in_e1, rd_e0, rd_e1;

    // Readiness looks at registered occupancy only, so fetch never relies on a same-cycle release.
    assign ready    = count_q <= CNT_W'(DEPTH - 2);
    assign wr_valid = (ready && !flush_i) ? bus.in_inst_valid : 2'b00;
    assign enq_n    = {1'b0, wr_valid[0]} + {1'b0, wr_valid[1]};

    always_comb begin
        avail = 2'b00;
        if (count_q >= CNT_W'(2))      avail = 2'b11;
        else if (count_q == CNT_W'(1)) avail = 2'b01;
    end

    assign out_valid = (bus.stall || flush_i) ? 2'b00 : avail;
    assign deq_n     = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    assign head_p1   = head_q + PTR_W'(1);
    assign wr_idx1   = wr_valid[0] ? tail_q + PTR_W'(1) : tail_q;

    assign in_e0 = '{inst: bus.in_inst_0, pc: bus.in_pc_0, taken: bus.in_pred_taken_0,
                     target: bus.in_pred_target_0, hist: bus.in_pred_hist_0};
    assign in_e1 = '{inst: bus.in_inst_1, pc: bus.in_pc_1, taken: bus.in_pred_taken_1,
                     target: bus.in_pred_target_1, hist: bus.in_pred_hist_1};

    always_comb begin
        head_d  = head_q + PTR_W'(deq_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is not reset: pointers and count alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (wr_valid[0]) mem_q[tail_q]  <= in_e0;
        if (wr_valid[1]) mem_q[wr_idx1] <= in_e1;
    end

    assign rd_e0 = out_valid[0] ? mem_q[head_q]  : '0;
    assign rd_e1 = out_valid[1] ? mem_q[head_p1] : '0;

    assign bus.in_ready          = ready;
    assign bus.count             = count_q;
    assign bus.out_inst_valid    = out_valid;
    assign bus.out_inst_0        = rd_e0.inst;
    assign bus.out_inst_1        = rd_e1.inst;
    assign bus.out_pc_0          = rd_e0.pc;
    assign bus.out_pc_1          = rd_e1.pc;
    assign bus.out_pred_taken_0  = rd_e0.taken;
    assign bus.out_pred_taken_1  = rd_e1.taken;
    assign bus.out_pred_target_0 = rd_e0.target;
    assign bus.out_pred_target_1 = rd_e1.target;
    assign bus.out_pred_hist_0   = rd_e0.hist;
    assign bus.out_pred_hist_1   = rd_e1.hist;
endmodule
